mem_lsu: RTL and testbench
==========================

// Module: mem_lsu
// PURPOSE
//  Memory-access stage of the 5-stage pipeline: sits between the EX/MEM register and the wb register.
//  Non-memory ops pass through unchanged; loads/stores run a req/ack transaction on the data-memory bus.
//  Provides big-endian byte/half/word lane steering, load sign/zero extension, misalignment and bus-timeout flags.
//  Raises mem_stallreq to the stall controller while an access is outstanding.
// PARAMETERS
//  TIMEOUT  16  cycles in BUSY without dm_ack before the access is abandoned (>=1)
// PORTS
//  clk           in   1   clock; all state updates on rising edge
//  reset         in   1   synchronous, active-high reset
//  stall         in   6   pipeline stall vector; stall[5] = wb register hold
//  flush         in   1   squash the instruction currently in this stage
//  ex_we/ex_waddr/ex_wdata  in  1/5/32  GPR write request from EX
//  ex_whilo/ex_hi/ex_lo     in  1/32/32 HI/LO write request from EX
//  ex_memop      in   4   0 NONE,1 LB,2 LBU,3 LH,4 LHU,5 LW,6 SB,7 SH,8 SW; 9-15 = NONE
//  ex_maddr      in   32  effective byte address
//  ex_sdata      in   32  store data (low bits significant for SB/SH)
//  dm_req/dm_we  out  1/1 bus request / write enable
//  dm_addr       out  32  {ex_maddr[31:2],2'b00}
//  dm_sel        out  4   byte enables, dm_sel[3] = bits 31:24
//  dm_wdata      out  32  replicated store data
//  dm_ack        in   1   one-cycle completion strobe
//  dm_rdata      in   32  read data, valid with dm_ack
//  mem_we/mem_waddr/mem_wdata, mem_whilo/mem_hi/mem_lo  out  to wb register
//  mem_stallreq  out  1   stall request to controller
//  mem_excp_ade  out  1   misaligned address (LH/LHU/SH addr[0]!=0; LW/SW addr[1:0]!=0)
//  mem_bus_err   out  1   access timed out
// BEHAVIOUR
//  Reset: state=IDLE, dm_req=0, dm_we=0, dm_sel=0, dm_addr=0, dm_wdata=0, counter=0, result reg=0,
//   squash flag=0, error flags=0; mem_* outputs are 0 while reset asserted.
//  FSM IDLE/BUSY/DONE; dm_* outputs registered.
//  IDLE: NONE op -> mem_* = ex_* combinationally, stallreq=0. Aligned mem op & !flush ->
//   stallreq=1, next BUSY with dm_req=1, dm_addr/dm_sel/dm_wdata/dm_we loaded.
//   Misaligned op -> no access, stay IDLE, mem_excp_ade=1, mem_we=0, mem_whilo=0, stallreq=0.
//  BUSY: dm_* held stable; stallreq=1; counter increments each cycle.
//   dm_ack=1 -> dm_req=0, load result latched, next DONE.
//   counter==TIMEOUT-1 without ack -> dm_req=0, bus_err latched, next DONE (timeout at cycle TIMEOUT).
//  DONE: stallreq=0; mem_wdata = latched result for loads, ex_wdata for stores; other mem_* = ex_*;
//   mem_bus_err=1 and mem_we=0 if timed out. Stay in DONE while stall[5]=1, else -> IDLE next edge.
//  Total latency for ack after N BUSY cycles: stallreq high N+1 cycles, result visible in DONE.
//  Lanes (big-endian): byte k=addr[1:0] -> sel=4'b1000>>k, data bits [31-8k -: 8]; half addr[1]=0 -> 1100
//   bits 31:16, addr[1]=1 -> 0011 bits 15:0; word -> 1111. Store data: SB {4{b}}, SH {2{h}}, SW as-is.
//  Loads: LB/LH sign-extend, LBU/LHU zero-extend; mem_we=ex_we. Stores: mem_we=ex_we (normally 0).
//  flush in IDLE/DONE -> mem_we=0, mem_whilo=0, next IDLE, no new request.
//  flush in BUSY -> handshake completes (dm_req not dropped before ack/timeout), squash flag set;
//   in DONE mem_we=0, mem_whilo=0, flags=0; squash cleared on leaving DONE.
//  Simultaneous dm_ack and timeout in same cycle: ack wins, bus_err=0.
//  dm_ack outside BUSY ignored. Reset mid-BUSY: dm_req=0 at next edge, transaction dropped.
// TESTING
//  LW 0x100, dm_ack 3 cycles after req, rdata 0xDEADBEEF -> stallreq 4 cycles, mem_wdata 0xDEADBEEF, mem_we=1.
//  LB 0x101 rdata 0x12F45678 -> sel 0100, mem_wdata 0xFFFFFFF4; LBU same -> 0x000000F4; LH 0x102 -> 0x00005678.
//  SH 0x102 sdata 0x0000ABCD -> dm_we=1, sel 0011, dm_wdata 0xABCDABCD, single req, released on ack.
//  LW 0x103 -> no dm_req, mem_excp_ade=1, mem_we=0, stallreq=0.
//  LW, no ack, TIMEOUT=16 -> dm_req falls after 16 BUSY cycles, mem_bus_err=1, mem_we=0; ack+timeout same cycle -> no err.
//  flush in BUSY then ack -> mem_we=0 in DONE; reset in BUSY -> dm_req=0, state IDLE next edge.

Source files
------------

// File: rtl/mem_lsu.sv
// rtl/mem_lsu.sv - memory-access stage: pass-through, data-bus req/ack, big-endian lane steering
module mem_lsu #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  stall,
    input  logic        flush,
    input  logic        ex_we,
    input  logic [4:0]  ex_waddr,
    input  logic [31:0] ex_wdata,
    input  logic        ex_whilo,
    input  logic [31:0] ex_hi,
    input  logic [31:0] ex_lo,
    input  logic [3:0]  ex_memop,
    input  logic [31:0] ex_maddr,
    input  logic [31:0] ex_sdata,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [3:0]  dm_sel,
    output logic [31:0] dm_wdata,
    input  logic        dm_ack,
    input  logic [31:0] dm_rdata,
    output logic        mem_we,
    output logic [4:0]  mem_waddr,
    output logic [31:0] mem_wdata,
    output logic        mem_whilo,
    output logic [31:0] mem_hi,
    output logic [31:0] mem_lo,
    output logic        mem_stallreq,
    output logic        mem_excp_ade,
    output logic        mem_bus_err
);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt;
    logic [31:0]   result;
    logic          squash, timed_out;

    logic          is_load, is_store, is_mem, misalign, launch, timeout;
    logic [1:0]    size;
    logic [3:0]    sel_c;
    logic [31:0]   wdata_c, load_c;
    logic [7:0]    byte_v;
    logic [15:0]   half_v;
    logic          stall_unused;

    assign stall_unused = ^stall[4:0];

    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        size     = 2'd2;
        case (ex_memop)
            4'd1, 4'd2: begin is_load = 1'b1;  size = 2'd0; end
            4'd3, 4'd4: begin is_load = 1'b1;  size = 2'd1; end
            4'd5:       begin is_load = 1'b1;  size = 2'd2; end
            4'd6:       begin is_store = 1'b1; size = 2'd0; end
            4'd7:       begin is_store = 1'b1; size = 2'd1; end
            4'd8:       begin is_store = 1'b1; size = 2'd2; end
            default: ;
        endcase
        is_mem   = is_load | is_store;
        misalign = is_mem && ((size == 2'd1 && ex_maddr[0]) ||
                              (size == 2'd2 && ex_maddr[1:0] != 2'b00));
        launch   = (state == IDLE) && is_mem && !misalign && !flush;
        timeout  = (state == BUSY) && !dm_ack && (cnt == CW'(TIMEOUT - 1));
    end

    // Big-endian lanes: byte 0 lives in bits 31:24.
    always_comb begin
        sel_c   = 4'b1111;
        wdata_c = ex_sdata;
        case (size)
            2'd0: begin
                sel_c   = 4'b1000 >> ex_maddr[1:0];
                wdata_c = {4{ex_sdata[7:0]}};
            end
            2'd1: begin
                sel_c   = ex_maddr[1] ? 4'b0011 : 4'b1100;
                wdata_c = {2{ex_sdata[15:0]}};
            end
            default: ;
        endcase
        byte_v = dm_rdata[{~ex_maddr[1:0], 3'b000} +: 8];
        half_v = ex_maddr[1] ? dm_rdata[15:0] : dm_rdata[31:16];
        case (ex_memop)
            4'd1:    load_c = {{24{byte_v[7]}}, byte_v};
            4'd2:    load_c = {24'd0, byte_v};
            4'd3:    load_c = {{16{half_v[15]}}, half_v};
            4'd4:    load_c = {16'd0, half_v};
            default: load_c = dm_rdata;
        endcase
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (launch) state_nx = BUSY;
            BUSY:    if (dm_ack || timeout) state_nx = DONE;
            DONE:    if (flush || !stall[5]) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            dm_req    <= 1'b0;
            dm_we     <= 1'b0;
            dm_addr   <= 32'd0;
            dm_sel    <= 4'd0;
            dm_wdata  <= 32'd0;
            cnt       <= '0;
            result    <= 32'd0;
            squash    <= 1'b0;
            timed_out <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    cnt       <= '0;
                    squash    <= 1'b0;
                    timed_out <= 1'b0;
                    if (launch) begin
                        dm_req   <= 1'b1;
                        dm_we    <= is_store;
                        dm_addr  <= {ex_maddr[31:2], 2'b00};
                        dm_sel   <= sel_c;
                        dm_wdata <= wdata_c;
                    end
                end
                BUSY: begin
                    cnt <= cnt + CW'(1);
                    if (flush) squash <= 1'b1;
                    // Ack takes priority over a timeout landing in the same cycle.
                    if (dm_ack) begin
                        dm_req <= 1'b0;
                        dm_we  <= 1'b0;
                        result <= load_c;
                    end else if (timeout) begin
                        dm_req    <= 1'b0;
                        dm_we     <= 1'b0;
                        timed_out <= 1'b1;
                    end
                end
                DONE: begin
                    if (state_nx == IDLE) begin
                        squash    <= 1'b0;
                        timed_out <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        mem_we       = ex_we;
        mem_waddr    = ex_waddr;
        mem_wdata    = ex_wdata;
        mem_whilo    = ex_whilo;
        mem_hi       = ex_hi;
        mem_lo       = ex_lo;
        mem_stallreq = 1'b0;
        mem_excp_ade = 1'b0;
        mem_bus_err  = 1'b0;
        if (reset) begin
            mem_we    = 1'b0;
            mem_waddr = 5'd0;
            mem_wdata = 32'd0;
            mem_whilo = 1'b0;
            mem_hi    = 32'd0;
            mem_lo    = 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (flush) begin
                        mem_we    = 1'b0;
                        mem_whilo = 1'b0;
                    end else if (misalign) begin
                        mem_excp_ade = 1'b1;
                        mem_we       = 1'b0;
                        mem_whilo    = 1'b0;
                    end else if (is_mem) begin
                        mem_stallreq = 1'b1;
                        mem_we       = 1'b0;
                        mem_whilo    = 1'b0;
                    end
                end
                BUSY: begin
                    mem_stallreq = 1'b1;
                    mem_we       = 1'b0;
                    mem_whilo    = 1'b0;
                end
                DONE: begin
                    if (is_load) mem_wdata = result;
                    if (squash || flush) begin
                        mem_we    = 1'b0;
                        mem_whilo = 1'b0;
                    end else if (timed_out) begin
                        mem_we      = 1'b0;
                        mem_bus_err = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_lsu.sv
// tb/tb_mem_lsu.sv - scoreboard bench for mem_lsu
module tb_mem_lsu;
    localparam int TIMEOUT = 16;
    localparam logic [31:0] WD = 32'h1357_9BDF;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  stall;
    logic        flush;
    logic        ex_we;
    logic [4:0]  ex_waddr;
    logic [31:0] ex_wdata;
    logic        ex_whilo;
    logic [31:0] ex_hi, ex_lo;
    logic [3:0]  ex_memop;
    logic [31:0] ex_maddr, ex_sdata;
    logic        dm_req, dm_we;
    logic [31:0] dm_addr;
    logic [3:0]  dm_sel;
    logic [31:0] dm_wdata;
    logic        dm_ack;
    logic [31:0] dm_rdata;
    logic        mem_we;
    logic [4:0]  mem_waddr;
    logic [31:0] mem_wdata;
    logic        mem_whilo;
    logic [31:0] mem_hi, mem_lo;
    logic        mem_stallreq, mem_excp_ade, mem_bus_err;

    mem_lsu #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .ex_we(ex_we), .ex_waddr(ex_waddr), .ex_wdata(ex_wdata),
        .ex_whilo(ex_whilo), .ex_hi(ex_hi), .ex_lo(ex_lo),
        .ex_memop(ex_memop), .ex_maddr(ex_maddr), .ex_sdata(ex_sdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_sel(dm_sel),
        .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .mem_whilo(mem_whilo), .mem_hi(mem_hi), .mem_lo(mem_lo),
        .mem_stallreq(mem_stallreq), .mem_excp_ade(mem_excp_ade),
        .mem_bus_err(mem_bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  sel;
        logic        we;
        logic [31:0] wdata;
    } bus_t;

    typedef struct {
        logic        we;
        logic [31:0] wdata;
        logic        chk_data;
        logic        berr;
        logic        ade;
        int          slen;
    } res_t;

    bus_t bus_q[$];
    res_t res_q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   scnt = 0;
    logic req_prev = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_bus(input logic [31:0] a, input logic [3:0] s, input logic w, input logic [31:0] d);
        bus_t b;
        b.addr = a; b.sel = s; b.we = w; b.wdata = d;
        bus_q.push_back(b);
    endtask

    task automatic push_res(input logic w, input logic [31:0] d, input logic cd,
                            input logic be, input logic ae, input int sl);
        res_t r;
        r.we = w; r.wdata = d; r.chk_data = cd; r.berr = be; r.ade = ae; r.slen = sl;
        res_q.push_back(r);
    endtask

    // Monitor: bus requests on dm_req rise, results when a stall window closes or ade fires.
    always @(negedge clk) begin
        bus_t b;
        res_t r;
        if (reset) begin
            scnt     = 0;
            req_prev = 1'b0;
        end else begin
            if (dm_req && !req_prev) begin
                if (bus_q.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL unexpected_req: got addr %h expected no request", dm_addr);
                end else begin
                    b = bus_q.pop_front();
                    chk("dm_addr", dm_addr, b.addr);
                    chk("dm_sel", {28'd0, dm_sel}, {28'd0, b.sel});
                    chk("dm_we", {31'd0, dm_we}, {31'd0, b.we});
                    chk("dm_wdata", dm_wdata, b.wdata);
                end
            end
            req_prev = dm_req;
            if (mem_stallreq) begin
                scnt++;
            end else if (scnt > 0 || mem_excp_ade) begin
                if (res_q.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL unexpected_result: got wdata %h expected no result", mem_wdata);
                end else begin
                    r = res_q.pop_front();
                    chk("mem_we", {31'd0, mem_we}, {31'd0, r.we});
                    if (r.chk_data) chk("mem_wdata", mem_wdata, r.wdata);
                    chk("mem_bus_err", {31'd0, mem_bus_err}, {31'd0, r.berr});
                    chk("mem_excp_ade", {31'd0, mem_excp_ade}, {31'd0, r.ade});
                    chk("stall_len", 32'(scnt), 32'(r.slen));
                end
                scnt = 0;
            end
        end
    end

    // Issue one access; returns in the first DONE cycle (#1 after the edge).
    task automatic access(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                          input logic [31:0] rdata, input int lat, input bit flb, output int busy);
        ex_memop = op; ex_maddr = addr; ex_sdata = sdata;
        ex_we = (op >= 4'd1 && op <= 4'd5); ex_waddr = 5'd7; ex_wdata = WD;
        @(posedge clk); #1;
        busy = 0;
        for (int c = 1; c <= TIMEOUT + 4; c++) begin
            flush    = flb && (c == 1);
            dm_ack   = (c == lat);
            dm_rdata = (c == lat) ? rdata : 32'h0BAD_0BAD;
            @(posedge clk); #1;
            dm_ack = 1'b0; flush = 1'b0; busy = c;
            if (!dm_req) break;
        end
    endtask

    task automatic finish_op();
        @(posedge clk); #1;
        ex_memop = 4'd0;
        stall = 6'd0;
        @(posedge clk); #1;
    endtask

    task automatic misaligned(input logic [3:0] op, input logic [31:0] addr);
        push_res(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 0);
        ex_memop = op; ex_maddr = addr; ex_we = 1'b1;
        @(posedge clk); #1;
        ex_memop = 4'd0;
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy;
        reset = 1'b1; stall = 6'd0; flush = 1'b0;
        ex_we = 1'b1; ex_waddr = 5'd9; ex_wdata = 32'hA5A5_0001;
        ex_whilo = 1'b1; ex_hi = 32'h1111_2222; ex_lo = 32'h3333_4444;
        ex_memop = 4'd0; ex_maddr = 32'd0; ex_sdata = 32'd0;
        dm_ack = 1'b0; dm_rdata = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_dm_req", {31'd0, dm_req}, 32'd0);
        chk("rst_dm_addr", dm_addr, 32'd0);
        chk("rst_dm_sel", {28'd0, dm_sel}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        chk("pass_we", {31'd0, mem_we}, 32'd1);
        chk("pass_waddr", {27'd0, mem_waddr}, 32'd9);
        chk("pass_wdata", mem_wdata, 32'hA5A5_0001);
        chk("pass_whilo", {31'd0, mem_whilo}, 32'd1);
        chk("pass_hi", mem_hi, 32'h1111_2222);
        chk("pass_lo", mem_lo, 32'h3333_4444);
        chk("pass_stall", {31'd0, mem_stallreq}, 32'd0);
        ex_memop = 4'd12; #1;
        chk("op12_stall", {31'd0, mem_stallreq}, 32'd0);
        dm_ack = 1'b1; flush = 1'b1; #1;
        chk("flush_we", {31'd0, mem_we}, 32'd0);
        chk("flush_whilo", {31'd0, mem_whilo}, 32'd0);
        @(posedge clk); #1;
        dm_ack = 1'b0; flush = 1'b0; ex_memop = 4'd0; ex_whilo = 1'b0;
        chk("stray_ack_req", {31'd0, dm_req}, 32'd0);

        push_bus(32'h100, 4'b1111, 1'b0, 32'd0);
        push_res(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0, 4);
        access(4'd5, 32'h100, 32'd0, 32'hDEAD_BEEF, 3, 1'b0, busy);
        chk("lw_busy", 32'(busy), 32'd3);
        finish_op();

        push_bus(32'h100, 4'b0100, 1'b0, 32'd0);
        push_res(1'b1, 32'hFFFF_FFF4, 1'b1, 1'b0, 1'b0, 2);
        access(4'd1, 32'h101, 32'd0, 32'h12F4_5678, 1, 1'b0, busy);
        finish_op();

        push_bus(32'h100, 4'b0100, 1'b0, 32'd0);
        push_res(1'b1, 32'h0000_00F4, 1'b1, 1'b0, 1'b0, 2);
        access(4'd2, 32'h101, 32'd0, 32'h12F4_5678, 1, 1'b0, busy);
        finish_op();

        push_bus(32'h100, 4'b0011, 1'b0, 32'd0);
        push_res(1'b1, 32'h0000_5678, 1'b1, 1'b0, 1'b0, 3);
        access(4'd3, 32'h102, 32'd0, 32'h12F4_5678, 2, 1'b0, busy);
        finish_op();

        push_bus(32'h100, 4'b1100, 1'b0, 32'd0);
        push_res(1'b1, 32'hFFFF_8001, 1'b1, 1'b0, 1'b0, 2);
        access(4'd3, 32'h100, 32'd0, 32'h8001_2345, 1, 1'b0, busy);
        finish_op();

        push_bus(32'h100, 4'b1100, 1'b0, 32'd0);
        push_res(1'b1, 32'h0000_8001, 1'b1, 1'b0, 1'b0, 2);
        access(4'd4, 32'h100, 32'd0, 32'h8001_2345, 1, 1'b0, busy);
        finish_op();

        push_bus(32'h100, 4'b0011, 1'b1, 32'hABCD_ABCD);
        push_res(1'b0, WD, 1'b1, 1'b0, 1'b0, 3);
        access(4'd7, 32'h102, 32'h0000_ABCD, 32'd0, 2, 1'b0, busy);
        finish_op();

        push_bus(32'h104, 4'b0001, 1'b1, 32'h7E7E_7E7E);
        push_res(1'b0, WD, 1'b1, 1'b0, 1'b0, 2);
        access(4'd6, 32'h107, 32'h0000_007E, 32'd0, 1, 1'b0, busy);
        finish_op();

        push_bus(32'h108, 4'b1111, 1'b1, 32'h1122_3344);
        push_res(1'b0, WD, 1'b1, 1'b0, 1'b0, 5);
        access(4'd8, 32'h108, 32'h1122_3344, 32'd0, 4, 1'b0, busy);
        finish_op();

        misaligned(4'd5, 32'h103);
        misaligned(4'd3, 32'h101);
        misaligned(4'd8, 32'h102);

        push_bus(32'h200, 4'b1111, 1'b0, 32'd0);
        push_res(1'b0, 32'd0, 1'b0, 1'b1, 1'b0, TIMEOUT + 1);
        access(4'd5, 32'h200, 32'd0, 32'd0, 0, 1'b0, busy);
        chk("timeout_busy", 32'(busy), 32'(TIMEOUT));
        finish_op();

        push_bus(32'h204, 4'b1111, 1'b0, 32'd0);
        push_res(1'b1, 32'hCAFE_F00D, 1'b1, 1'b0, 1'b0, TIMEOUT + 1);
        access(4'd5, 32'h204, 32'd0, 32'hCAFE_F00D, TIMEOUT, 1'b0, busy);
        finish_op();

        push_bus(32'h300, 4'b1111, 1'b0, 32'd0);
        push_res(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 3);
        access(4'd5, 32'h300, 32'd0, 32'h5A5A_5A5A, 2, 1'b1, busy);
        finish_op();

        stall = 6'b10_0000;
        push_bus(32'h108, 4'b0001, 1'b0, 32'd0);
        push_res(1'b1, 32'h0000_00A9, 1'b1, 1'b0, 1'b0, 2);
        access(4'd2, 32'h10B, 32'd0, 32'h0000_00A9, 1, 1'b0, busy);
        @(posedge clk); #1;
        chk("hold_wdata", mem_wdata, 32'h0000_00A9);
        chk("hold_stall", {31'd0, mem_stallreq}, 32'd0);
        finish_op();

        push_bus(32'h400, 4'b1111, 1'b0, 32'd0);
        ex_memop = 4'd5; ex_maddr = 32'h400; ex_sdata = 32'd0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1; ex_memop = 4'd0;
        @(posedge clk); #1;
        chk("rst_busy_req", {31'd0, dm_req}, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_req", {31'd0, dm_req}, 32'd0);
        chk("post_rst_stall", {31'd0, mem_stallreq}, 32'd0);
        @(posedge clk); #1;

        chk("bus_q_empty", 32'(bus_q.size()), 32'd0);
        chk("res_q_empty", 32'(res_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
